// File: rtl/multi_issue_inst_queue_if.sv
// Handshake bundle for multi_issue_inst_queue: enqueue lanes, dequeue lanes,
// flush and occupancy. The producer/consumer side uses the master modport and
// the queue uses the slave modport.
interface multi_issue_inst_queue_if #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int ENQ_LANES = 2,
    parameter int DEQ_LANES = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                           flush_in;
    logic [ENQ_LANES-1:0]           enq_valid_in;
    logic [ENQ_LANES*WIDTH-1:0]     enq_data_in;
    logic                           enq_ready_out;
    logic [DEQ_LANES-1:0]           deq_valid_out;
    logic [DEQ_LANES*WIDTH-1:0]     deq_data_out;
    logic [DEQ_LANES-1:0]           deq_pop_in;
    logic [CW-1:0]                  count_out;

    modport master (
        output flush_in, enq_valid_in, enq_data_in, deq_pop_in,
        input  enq_ready_out, deq_valid_out, deq_data_out, count_out
    );

    modport slave (
        input  flush_in, enq_valid_in, enq_data_in, deq_pop_in,
        output enq_ready_out, deq_valid_out, deq_data_out, count_out
    );
endinterface

// File: rtl/multi_issue_inst_queue.sv
// Multi-issue instruction queue: circular buffer accepting up to ENQ_LANES
// entries and presenting the DEQ_LANES oldest entries every cycle.
// Pointers carry one extra wrap bit so that full and empty are distinct and
// occupancy is simply wr_ptr - rd_ptr.
// Optional feature macro INSTQ_BYPASS_EN: when the queue is empty the enqueue
// lanes fall through combinationally to the dequeue lanes; lanes consumed in
// that same cycle are never written, the rest are stored in order.
module multi_issue_inst_queue #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int ENQ_LANES = 2,
    parameter int DEQ_LANES = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    multi_issue_inst_queue_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // Storage is deliberately not reset; the pointers alone define validity.
    logic [WIDTH-1:0]               mem [DEPTH];

    logic [PW-1:0]                  wr_ptr;
    logic [PW-1:0]                  rd_ptr;
    logic [PW-1:0]                  count;
    logic                           enq_ready;
    logic                           do_enq;
    logic                           byp;

    // Lane counts share the pointer width; DEPTH >= lane counts so they fit.
    logic [PW-1:0]                  enq_n;
    logic [PW-1:0]                  pop_n;
    logic [PW-1:0]                  skip;
    logic [PW-1:0]                  wr_adv;
    logic [PW-1:0]                  rd_adv;

    logic [DEQ_LANES-1:0]           deq_valid;
    logic [ENQ_LANES-1:0][PW-1:0]   waddr;
    logic [ENQ_LANES-1:0]           wen;

    // Occupancy and readiness come from the registered pointers only, so a
    // slot freed by a dequeue this cycle is not reusable until next cycle.
    assign count     = wr_ptr - rd_ptr;
    assign enq_ready = (count <= PW'(DEPTH - ENQ_LANES));

`ifdef INSTQ_BYPASS_EN
    // Fall-through is active only for an empty, live (not flushing, not in
    // reset) queue.
    assign byp = (count == '0) && !bus.flush_in && rst_n_in;
`else
    assign byp = 1'b0;
`endif

    // Number of enqueue lanes in the contiguous valid prefix from lane 0.
    always_comb begin
        logic run;
        enq_n = '0;
        run   = 1'b1;
        for (int i = 0; i < ENQ_LANES; i++) begin
            run = run & bus.enq_valid_in[i];
            if (run) enq_n = enq_n + PW'(1);
        end
    end

    // Per dequeue lane: validity and data, either from storage or (bypass
    // build only) straight from the matching enqueue lane.
    for (genvar k = 0; k < DEQ_LANES; k++) begin : g_deq
        logic [PW-1:0]    raddr;
        logic [WIDTH-1:0] stored;
        logic             stored_vld;

        assign raddr      = rd_ptr + PW'(k);
        assign stored     = mem[raddr[IW-1:0]];
        assign stored_vld = (count > PW'(k));

`ifdef INSTQ_BYPASS_EN
        if (k < ENQ_LANES) begin : g_fall
            assign deq_valid[k] = byp ? (enq_n > PW'(k)) : stored_vld;
            assign bus.deq_data_out[k*WIDTH +: WIDTH] =
                byp ? bus.enq_data_in[k*WIDTH +: WIDTH] : stored;
        end else begin : g_nofall
            assign deq_valid[k] = byp ? 1'b0 : stored_vld;
            assign bus.deq_data_out[k*WIDTH +: WIDTH] = stored;
        end
`else
        assign deq_valid[k] = stored_vld;
        assign bus.deq_data_out[k*WIDTH +: WIDTH] = stored;
`endif
    end

    // Number of dequeue lanes actually consumed: contiguous prefix of
    // pop requests on lanes that are valid.
    always_comb begin
        logic run;
        pop_n = '0;
        run   = 1'b1;
        for (int k = 0; k < DEQ_LANES; k++) begin
            run = run & bus.deq_pop_in[k] & deq_valid[k];
            if (run) pop_n = pop_n + PW'(1);
        end
    end

    // Pointer advances and per-lane write enables/addresses. In bypass the
    // popped lanes are the leading enqueue lanes, so they are skipped and the
    // remaining lanes are packed down starting at wr_ptr.
    always_comb begin
        do_enq = enq_ready && !bus.flush_in;
        skip   = byp ? pop_n : '0;
        wr_adv = do_enq ? (enq_n - skip) : '0;
        rd_adv = byp ? '0 : pop_n;
        for (int i = 0; i < ENQ_LANES; i++) begin
            waddr[i] = wr_ptr + PW'(i) - skip;
            wen[i]   = do_enq && (PW'(i) < enq_n) && (PW'(i) >= skip);
        end
    end

    // Pointer state: async reset, flush overrides any same-cycle traffic.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + wr_adv;
            rd_ptr <= rd_ptr + rd_adv;
        end
    end

    // Entry storage writes, one port per enqueue lane.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < ENQ_LANES; i++) begin
            if (wen[i]) mem[waddr[i][IW-1:0]] <= bus.enq_data_in[i*WIDTH +: WIDTH];
        end
    end

    assign bus.enq_ready_out = enq_ready;
    assign bus.deq_valid_out = deq_valid;
    assign bus.count_out     = count;

endmodule

// File: tb/tb_multi_issue_inst_queue.sv
// Directed bench for multi_issue_inst_queue (WIDTH=32, DEPTH=8, 2x2 lanes).
module tb_multi_issue_inst_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int NL    = 2;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    multi_issue_inst_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ENQ_LANES(NL), .DEQ_LANES(NL)) bus ();

    multi_issue_inst_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ENQ_LANES(NL), .DEQ_LANES(NL)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [1:0]  ev;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  pop;
        logic [3:0]  cnt;
        logic [1:0]  vld;
        logic        rdy;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.flush_in     = 1'b0;
        bus.enq_valid_in = 2'b00;
        bus.enq_data_in  = '0;
        bus.deq_pop_in   = 2'b00;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        bus.flush_in     = v.flush;
        bus.enq_valid_in = v.ev;
        bus.enq_data_in  = {v.e1, v.e0};
        bus.deq_pop_in   = v.pop;
        @(posedge clk);
        #1 idle();
        #1;
        chk($sformatf("row%0d_count", idx), 32'(bus.count_out), 32'(v.cnt));
        chk($sformatf("row%0d_valid", idx), 32'(bus.deq_valid_out), 32'(v.vld));
        chk($sformatf("row%0d_ready", idx), 32'(bus.enq_ready_out), 32'(v.rdy));
        if (v.vld[0]) chk($sformatf("row%0d_d0", idx), bus.deq_data_out[31:0], v.d0);
        if (v.vld[1]) chk($sformatf("row%0d_d1", idx), bus.deq_data_out[63:32], v.d1);
    endtask

    // Watchdog: the run must always end on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent;
        int got;
        n_chk  = 0;
        n_fail = 0;

        //            flush  ev     e0      e1      pop    cnt   vld    rdy   d0      d1
        vecs[0]  = '{1'b0, 2'b11, 32'hA0, 32'hB0, 2'b00, 4'd2, 2'b11, 1'b1, 32'hA0, 32'hB0};
        vecs[1]  = '{1'b0, 2'b11, 32'hC1, 32'hC2, 2'b01, 4'd3, 2'b11, 1'b1, 32'hB0, 32'hC1};
        vecs[2]  = '{1'b0, 2'b10, 32'hEE, 32'hEF, 2'b10, 4'd3, 2'b11, 1'b1, 32'hB0, 32'hC1};
        vecs[3]  = '{1'b0, 2'b01, 32'hD1, 32'hDD, 2'b11, 4'd2, 2'b11, 1'b1, 32'hC2, 32'hD1};
        vecs[4]  = '{1'b0, 2'b11, 32'hE1, 32'hE2, 2'b00, 4'd4, 2'b11, 1'b1, 32'hC2, 32'hD1};
        vecs[5]  = '{1'b0, 2'b11, 32'hF1, 32'hF2, 2'b00, 4'd6, 2'b11, 1'b1, 32'hC2, 32'hD1};
        vecs[6]  = '{1'b0, 2'b11, 32'h61, 32'h62, 2'b00, 4'd8, 2'b11, 1'b0, 32'hC2, 32'hD1};
        vecs[7]  = '{1'b0, 2'b11, 32'h71, 32'h72, 2'b00, 4'd8, 2'b11, 1'b0, 32'hC2, 32'hD1};
        vecs[8]  = '{1'b0, 2'b11, 32'h81, 32'h82, 2'b11, 4'd6, 2'b11, 1'b1, 32'hE1, 32'hE2};
        vecs[9]  = '{1'b0, 2'b00, 32'h0,  32'h0,  2'b01, 4'd5, 2'b11, 1'b1, 32'hE2, 32'hF1};
        vecs[10] = '{1'b1, 2'b11, 32'h91, 32'h92, 2'b11, 4'd0, 2'b00, 1'b1, 32'h0,  32'h0};
        vecs[11] = '{1'b0, 2'b11, 32'hA1, 32'hA2, 2'b00, 4'd2, 2'b11, 1'b1, 32'hA1, 32'hA2};

        // Reset values while reset is held
        rst_n = 1'b0;
        idle();
        #12;
        chk("rst_count", 32'(bus.count_out), 32'd0);
        chk("rst_valid", 32'(bus.deq_valid_out), 32'd0);
        chk("rst_ready", 32'(bus.enq_ready_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) apply(vecs[i], i);

        // Streaming 20 entries, 2-in/2-out, across several pointer wraps
        @(negedge clk);
        bus.flush_in = 1'b1;
        @(posedge clk);
        #1 idle();
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60 && got < 20; cyc++) begin
            @(negedge clk);
            bus.enq_valid_in = (sent < 20) ? 2'b11 : 2'b00;
            bus.enq_data_in  = {32'(sent + 1), 32'(sent)};
            bus.deq_pop_in   = 2'b00;
            #1;
            bus.deq_pop_in = bus.deq_valid_out;
            if (bus.deq_valid_out[0]) begin
                chk("stream_lane0", bus.deq_data_out[31:0], 32'(got));
                got++;
            end
            if (bus.deq_valid_out[1]) begin
                chk("stream_lane1", bus.deq_data_out[63:32], 32'(got));
                got++;
            end
            if (bus.enq_ready_out && sent < 20) sent += 2;
            @(posedge clk);
            #1;
        end
        idle();
        chk("stream_total", 32'(got), 32'd20);
        #1 chk("stream_empty", 32'(bus.count_out), 32'd0);

        // Asynchronous reset mid-operation with three entries held
        @(negedge clk);
        bus.enq_valid_in = 2'b11;
        bus.enq_data_in  = {32'h52, 32'h51};
        @(negedge clk);
        bus.enq_valid_in = 2'b01;
        bus.enq_data_in  = {32'h0, 32'h53};
        @(posedge clk);
        #1 idle();
        #1 chk("pre_rst_count", 32'(bus.count_out), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(bus.count_out), 32'd0);
        chk("async_rst_valid", 32'(bus.deq_valid_out), 32'd0);
        chk("async_rst_ready", 32'(bus.enq_ready_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.enq_valid_in = 2'b01;
        bus.enq_data_in  = {32'h0, 32'h4B};
        @(posedge clk);
        #1 idle();
        #1;
        chk("post_rst_count", 32'(bus.count_out), 32'd1);
        chk("post_rst_valid", 32'(bus.deq_valid_out), 32'd1);
        chk("post_rst_d0", bus.deq_data_out[31:0], 32'h4B);

`ifdef INSTQ_BYPASS_EN
        // Empty-queue fall-through: X,Y offered, lane 0 popped same cycle
        @(negedge clk);
        bus.flush_in = 1'b1;
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        bus.enq_valid_in = 2'b11;
        bus.enq_data_in  = {32'h59, 32'h58};
        bus.deq_pop_in   = 2'b01;
        #1;
        chk("byp_valid", 32'(bus.deq_valid_out), 32'd3);
        chk("byp_d0", bus.deq_data_out[31:0], 32'h58);
        @(posedge clk);
        #1 idle();
        #1;
        chk("byp_count", 32'(bus.count_out), 32'd1);
        chk("byp_next_valid", 32'(bus.deq_valid_out), 32'd1);
        chk("byp_next_d0", bus.deq_data_out[31:0], 32'h59);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_issue_inst_queue.md
MULTI_ISSUE_INST_QUEUE -- requirements
Module: multi_issue_inst_queue

Interface
REQ-001 Parameter WIDTH, default 32: bits per queue entry.
REQ-002 Parameter DEPTH, default 8: entry count; power of two, >= 4, >= ENQ_LANES and >= DEQ_LANES.
REQ-003 Parameter ENQ_LANES, default 2: entries offered per cycle, 1..4.
REQ-004 Parameter DEQ_LANES, default 2: entries presented per cycle, 1..4.
REQ-005 clk_in  input  1  clock; all state on rising edge.
REQ-006 rst_n_in  input  1  asynchronous, active-low reset.
REQ-007 flush_in  input  1  discard all entries (mispredict/redirect).
REQ-008 enq_valid_in  input  ENQ_LANES  per-lane valid; contiguous from lane 0.
REQ-009 enq_data_in  input  ENQ_LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
REQ-010 enq_ready_out  output  1  high when free slots >= ENQ_LANES.
REQ-011 deq_valid_out  output  DEQ_LANES  lane k high when occupancy > k.
REQ-012 deq_data_out  output  DEQ_LANES*WIDTH  lane k = k-th oldest entry.
REQ-013 deq_pop_in  input  DEQ_LANES  per-lane consume; contiguous from lane 0.
REQ-014 count_out  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-015 Storage SHALL be a circular buffer; read/write pointers $clog2(DEPTH)+1 bits, index = low $clog2(DEPTH) bits, extra bit distinguishes full from empty.
REQ-016 Enqueue: on a rising edge with enq_ready_out high, every lane i with enq_valid_in[i] high SHALL be written at write pointer + i, in lane order; pointer advances by popcount(enq_valid_in).
REQ-017 With enq_ready_out low, enq_valid_in SHALL be ignored and no state change from the enqueue side.
REQ-018 Dequeue: pop count = number of lanes k with deq_pop_in[k] and deq_valid_out[k] both high; read pointer advances by that count.
REQ-019 Non-contiguous enq_valid_in or deq_pop_in SHALL use only the contiguous prefix from lane 0; higher lanes ignored.
REQ-020 Simultaneous enqueue and dequeue SHALL both take effect; count_out next = count + enq - deq.
REQ-021 Enqueue readiness SHALL use pre-dequeue occupancy (no same-cycle slot reuse).
REQ-022 Without bypass, written entries SHALL appear on deq_data_out one cycle after the write edge.
REQ-023 flush_in high SHALL, at that edge, reset both pointers to 0 and override any same-cycle enqueue and dequeue; count_out = 0 next cycle.
REQ-024 Pointer wrap past DEPTH-1 SHALL preserve FIFO order with no lost or duplicated entries.
REQ-025 deq_data_out for lanes with deq_valid_out low is don't-care.

Reset
REQ-026 rst_n_in low SHALL asynchronously clear both pointers; count_out = 0, deq_valid_out = 0, enq_ready_out = 1 while held.
REQ-027 Storage contents SHALL NOT be reset.
REQ-028 Reset mid-operation SHALL discard all entries; first post-release entry appears on lane 0.

Configuration
REQ-029 Macro INSTQ_BYPASS_EN SHALL enable empty-queue fall-through.
REQ-030 With INSTQ_BYPASS_EN defined and count = 0 with no flush: deq_valid_out/deq_data_out SHALL reflect enq lanes combinationally same cycle; popped lanes SHALL not be stored, remainder stored in order.
REQ-031 Without INSTQ_BYPASS_EN: no combinational path from enq_* to deq_*; REQ-022 latency holds.

Verification
REQ-032 Reset then enqueue A,B (2 lanes) -> next cycle deq_valid_out=2'b11, data A,B, count_out=2.
REQ-033 Fill DEPTH=8 with 8 entries -> enq_ready_out=0, count_out=8; further enqueues ignored; pop 2 -> count_out=6, enq_ready_out=1.
REQ-034 Streaming 20 entries with simultaneous 2-in/2-out across wrap -> output order exactly 0..19, no gaps.
REQ-035 count=5, flush_in plus enqueue 2 same cycle -> count_out=0, deq_valid_out=0 next cycle.
REQ-036 rst_n_in low mid-cycle with count=3 -> count_out=0 immediately without clock edge.
REQ-037 INSTQ_BYPASS_EN, empty, enqueue X,Y with pop lane 0 only -> X on lane 0 same cycle; next cycle count_out=1, lane 0 = Y.
